// File: rtl/enc_tx_sched_if.sv
// Byte-stream handshake between the two requesters and the encoder transmit scheduler.
interface enc_tx_sched_if;
    logic       s0_valid;
    logic [7:0] s0_data;
    logic       s0_last;
    logic       s0_ready;
    logic       s1_valid;
    logic [7:0] s1_data;
    logic       s1_last;
    logic       s1_ready;

    modport master (
        output s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last,
        input  s0_ready, s1_ready
    );

    modport slave (
        input  s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last,
        output s0_ready, s1_ready
    );
endinterface

// File: rtl/enc_tx_sched.sv
// Shares one 8b/10b encoder between two byte requesters: idles, SOF/EOF delimiters, payload, fill, error.
// Optional clock-compensation K28.0 pairs are built when CLK_COMP_EN is defined.
module enc_tx_sched #(
    parameter int SYNC_LEN    = 4,
    parameter int IFG_LEN     = 2,
    parameter int MAX_LEN     = 64,
    parameter int CC_INTERVAL = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               link_en,
    enc_tx_sched_if.slave      req,
    output logic [7:0]         enc_eb,
    output logic               enc_k,
    output logic [1:0]         grant,
    output logic               busy,
    output logic               frame_err
);

    localparam logic [3:0] S_SYNC  = 4'd0;
    localparam logic [3:0] S_IDLE  = 4'd1;
    localparam logic [3:0] S_SOF   = 4'd2;
    localparam logic [3:0] S_DATA  = 4'd3;
    localparam logic [3:0] S_EOF   = 4'd4;
    localparam logic [3:0] S_ERR   = 4'd5;
    localparam logic [3:0] S_DRAIN = 4'd6;
    localparam logic [3:0] S_GAP   = 4'd7;
    localparam logic [3:0] S_CC    = 4'd8;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K30_7 = 8'hFE;
    localparam logic [7:0] K28_0 = 8'h1C;

    logic [3:0]  state_q,   state_d;
    logic [15:0] tmr_q,     tmr_d;
    logic [7:0]  cnt_q,     cnt_d;
    logic [1:0]  grant_q,   grant_d;
    logic        prio_q,    prio_d;
    logic [7:0]  enc_eb_q,  enc_eb_d;
    logic        enc_k_q,   enc_k_d;
    logic        cc_clr;

    logic        sel_valid;
    logic        sel_last;
    logic [7:0]  sel_data;
    logic        rdy_phase;
    logic        xfer;

    // The latched grant selects which requester feeds the payload path.
    always_comb begin
        sel_valid = grant_q[1] ? req.s1_valid : req.s0_valid;
        sel_last  = grant_q[1] ? req.s1_last  : req.s0_last;
        sel_data  = grant_q[1] ? req.s1_data  : req.s0_data;
        rdy_phase = (state_q == S_DATA) || (state_q == S_DRAIN);
        xfer      = rdy_phase && sel_valid;
    end

    assign req.s0_ready = rdy_phase & grant_q[0];
    assign req.s1_ready = rdy_phase & grant_q[1];

`ifdef CLK_COMP_EN
    logic [15:0] cc_cnt_q, cc_cnt_d;
    logic        cc_pend_q, cc_pend_d;
    logic        cc_wrap;

    always_comb begin
        cc_wrap   = (cc_cnt_q == 16'(CC_INTERVAL - 1));
        cc_cnt_d  = cc_wrap ? '0 : cc_cnt_q + 16'd1;
        cc_pend_d = cc_wrap ? 1'b1 : (cc_clr ? 1'b0 : cc_pend_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cc_cnt_q  <= '0;
            cc_pend_q <= 1'b0;
        end else begin
            cc_cnt_q  <= cc_cnt_d;
            cc_pend_q <= cc_pend_d;
        end
    end
`else
    logic cc_unused;
    assign cc_unused = (CC_INTERVAL == 0) | cc_clr;
`endif

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        prio_d   = prio_q;
        enc_eb_d = K28_5;
        enc_k_d  = 1'b1;
        cc_clr   = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (tmr_q == 16'(SYNC_LEN - 1)) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            S_IDLE: begin
`ifdef CLK_COMP_EN
                if (cc_pend_q) begin
                    enc_eb_d = K28_0;
                    state_d  = S_CC;
                end else
`endif
                if (link_en && (req.s0_valid || req.s1_valid)) begin
                    // On a tie prio_q names the requester that was not served last.
                    if (req.s0_valid && req.s1_valid)
                        grant_d = prio_q ? 2'b10 : 2'b01;
                    else
                        grant_d = req.s0_valid ? 2'b01 : 2'b10;
                    state_d = S_SOF;
                end
            end
            S_CC: begin
                enc_eb_d = K28_0;
                cc_clr   = 1'b1;
                state_d  = S_IDLE;
            end
            S_SOF: begin
                enc_eb_d = K27_7;
                cnt_d    = '0;
                state_d  = S_DATA;
            end
            S_DATA: begin
                if (xfer) begin
                    enc_eb_d = sel_data;
                    enc_k_d  = 1'b0;
                    cnt_d    = cnt_q + 8'd1;
                    if (sel_last)
                        state_d = S_EOF;
                    else if (cnt_q + 8'd1 == 8'(MAX_LEN))
                        state_d = S_ERR;
                end else begin
                    enc_eb_d = K23_7;
                end
            end
            S_EOF: begin
                enc_eb_d = K29_7;
                prio_d   = ~grant_q[1];
                grant_d  = '0;
                tmr_d    = '0;
                state_d  = S_GAP;
            end
            S_ERR: begin
                enc_eb_d = K30_7;
                state_d  = S_DRAIN;
            end
            S_DRAIN: begin
                if (xfer && sel_last) begin
                    grant_d = '0;
                    tmr_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tmr_q == 16'(IFG_LEN - 1)) begin
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_SYNC;
            tmr_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            prio_q   <= 1'b0;
            enc_eb_q <= K28_5;
            enc_k_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            prio_q   <= prio_d;
            enc_eb_q <= enc_eb_d;
            enc_k_q  <= enc_k_d;
        end
    end

    assign enc_eb    = enc_eb_q;
    assign enc_k     = enc_k_q;
    assign grant     = grant_q;
    assign busy      = (state_q == S_SOF) || (state_q == S_DATA) || (state_q == S_EOF) ||
                       (state_q == S_ERR) || (state_q == S_DRAIN);
    assign frame_err = (state_q == S_ERR);

endmodule

// File: tb/tb_enc_tx_sched.sv
// Scoreboard bench for enc_tx_sched: a frame-level reference model predicts every symbol and control output.
module tb_enc_tx_sched;
    localparam int SYNC_LEN = 4;
    localparam int IFG_LEN  = 2;
    localparam int MAX_LEN  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       link_en = 1'b0;
    logic [7:0] enc_eb;
    logic       enc_k;
    logic [1:0] grant;
    logic       busy;
    logic       frame_err;

    enc_tx_sched_if bus();

    enc_tx_sched #(
        .SYNC_LEN(SYNC_LEN),
        .IFG_LEN(IFG_LEN),
        .MAX_LEN(MAX_LEN),
        .CC_INTERVAL(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .link_en(link_en),
        .req(bus),
        .enc_eb(enc_eb),
        .enc_k(enc_k),
        .grant(grant),
        .busy(busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- requesters: queues of {last,data} ----------------
    logic [8:0] pq0[$];
    logic [8:0] pq1[$];
    int         pct0 = 100;
    int         pct1 = 100;
    logic       acc0, acc1;

    always @(negedge clk) begin
        acc0 <= !reset && bus.s0_valid && bus.s0_ready;
        acc1 <= !reset && bus.s1_valid && bus.s1_ready;
    end

    always @(posedge clk) begin
        #1;
        if (acc0 && pq0.size() > 0) void'(pq0.pop_front());
        if (acc1 && pq1.size() > 0) void'(pq1.pop_front());
        bus.s0_valid = (pq0.size() > 0) && ($urandom_range(99) < pct0);
        bus.s0_data  = (pq0.size() > 0) ? pq0[0][7:0] : 8'h00;
        bus.s0_last  = (pq0.size() > 0) ? pq0[0][8] : 1'b0;
        bus.s1_valid = (pq1.size() > 0) && ($urandom_range(99) < pct1);
        bus.s1_data  = (pq1.size() > 0) ? pq1[0][7:0] : 8'h00;
        bus.s1_last  = (pq1.size() > 0) ? pq1[0][8] : 1'b0;
    end

    task automatic push_frame(input int r, input int len);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            if (r == 0) pq0.push_back({(i == len - 1), b});
            else        pq1.push_back({(i == len - 1), b});
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] sym;
        logic       k;
        logic [1:0] gnt;
        logic       bsy;
        logic       err;
    } step_t;

    typedef struct packed {
        logic [7:0] sym;
        logic       k;
    } sym_t;

    step_t fixq[$];   // scripted cycles: sync, SOF, EOF/ERR, inter-frame gap
    sym_t  sbq[$];    // expected symbols, consumed by the monitor
    int    owner;
    bit    in_data;
    bit    draining;
    int    cnt;
    int    prio;
    bit    model_on = 1'b0;

    function automatic step_t mk(input logic [7:0] s, input logic [1:0] g, input logic b, input logic e);
        step_t t;
        t.sym = s; t.k = 1'b1; t.gnt = g; t.bsy = b; t.err = e;
        return t;
    endfunction

    function automatic void push_gap();
        for (int i = 0; i < IFG_LEN; i++) fixq.push_back(mk(8'hBC, 2'b00, 1'b0, 1'b0));
    endfunction

    function automatic void model_reset();
        fixq.delete();
        sbq.delete();
        in_data = 0; draining = 0; owner = 0; cnt = 0; prio = 0;
        for (int i = 0; i < SYNC_LEN; i++) fixq.push_back(mk(8'hBC, 2'b00, 1'b0, 1'b0));
    endfunction

    task automatic model_step();
        step_t      st;
        sym_t       out;
        logic [1:0] g;
        logic       b, e, r0, r1, vld, lst;
        logic [7:0] dat;
        g = 2'b00; b = 1'b0; e = 1'b0; r0 = 1'b0; r1 = 1'b0;
        out.sym = 8'hBC; out.k = 1'b1;
        vld = owner ? bus.s1_valid : bus.s0_valid;
        lst = owner ? bus.s1_last  : bus.s0_last;
        dat = owner ? bus.s1_data  : bus.s0_data;
        if (fixq.size() > 0) begin
            st = fixq.pop_front();
            out.sym = st.sym; out.k = st.k; g = st.gnt; b = st.bsy; e = st.err;
        end else if (in_data || draining) begin
            g = owner ? 2'b10 : 2'b01;
            b = 1'b1;
            r0 = (owner == 0); r1 = (owner == 1);
            if (in_data) begin
                if (vld) begin
                    out.sym = dat; out.k = 1'b0; cnt++;
                    if (lst) begin
                        fixq.push_back(mk(8'hFD, g, 1'b1, 1'b0));
                        push_gap();
                        prio = 1 - owner;
                        in_data = 0;
                    end else if (cnt == MAX_LEN) begin
                        fixq.push_back(mk(8'hFE, g, 1'b1, 1'b1));
                        in_data = 0;
                        draining = 1;
                    end
                end else begin
                    out.sym = 8'hF7;
                end
            end else if (vld && lst) begin
                push_gap();
                draining = 0;
            end
        end else if (link_en && (bus.s0_valid || bus.s1_valid)) begin
            if (bus.s0_valid && bus.s1_valid) owner = prio;
            else                              owner = bus.s0_valid ? 0 : 1;
            fixq.push_back(mk(8'hFB, owner ? 2'b10 : 2'b01, 1'b1, 1'b0));
            in_data = 1;
            cnt = 0;
        end
        check("ctl{grant,busy,ferr,r1,r0}", {grant, busy, frame_err, bus.s1_ready, bus.s0_ready},
              {g, b, e, r1, r0});
        sbq.push_back(out);
    endtask

    always @(negedge clk) begin
        if (!reset && model_on) model_step();
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        sym_t x;
        #2;
        if (!reset && sbq.size() > 0) begin
            x = sbq.pop_front();
            check("symbol{k,eb}", {enc_k, enc_eb}, {x.k, x.sym});
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_eb"}, {enc_k, enc_eb}, {1'b1, 8'hBC});
        check({tag, "_ready"}, {bus.s1_ready, bus.s0_ready}, 2'b00);
        check({tag, "_grant_busy_ferr"}, {grant, busy, frame_err}, 4'b0000);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        model_on = 1'b1;
    endtask

    int         seen;
    int         rdy_cnt;
    int         ferr_cnt;
    logic [1:0] gseq[3];
    logic [1:0] prev_g;
    bit         found;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        release_reset();
        link_en = 1'b1;

        // idle after sync: model expects continuous K28.5
        repeat (12) @(posedge clk);

        // tie between two one-byte requesters: grants alternate starting with s0
        for (int i = 0; i < 3; i++) begin
            push_frame(0, 1);
            push_frame(1, 1);
        end
        seen = 0; prev_g = 2'b00;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (grant != 2'b00 && grant != prev_g && seen < 3) begin
                gseq[seen] = grant;
                seen++;
            end
            prev_g = grant;
        end
        check("tie_grant0", 32'(gseq[0]), 32'd1);
        check("tie_grant1", 32'(gseq[1]), 32'd2);
        check("tie_grant2", 32'(gseq[2]), 32'd1);

        // 3-byte frame 11,22,33 on s0
        pq0.push_back({1'b0, 8'h11});
        pq0.push_back({1'b0, 8'h22});
        pq0.push_back({1'b1, 8'h33});
        rdy_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.s0_ready) rdy_cnt++;
        end
        check("s0_ready_cycles", 32'(rdy_cnt), 32'd3);

        // over-length frame: 6 bytes with MAX_LEN=4, then a normal one
        push_frame(0, 6);
        push_frame(0, 2);
        ferr_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (frame_err) ferr_cnt++;
        end
        check("frame_err_pulses", 32'(ferr_cnt), 32'd1);

        // frame exactly MAX_LEN long with last on the final byte is normal
        push_frame(1, MAX_LEN);
        ferr_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (frame_err) ferr_cnt++;
        end
        check("maxlen_last_no_err", 32'(ferr_cnt), 32'd0);

        // randomized traffic with fills and link_en toggling
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            if (c % 100 == 0) begin
                pct0 = 40 + int'($urandom_range(60));
                pct1 = 40 + int'($urandom_range(60));
            end
            if (c % 20 == 0) link_en = ($urandom_range(7) != 0);
            if (pq0.size() == 0 && $urandom_range(7) == 0) push_frame(0, 1 + int'($urandom_range(5)));
            if (pq1.size() == 0 && $urandom_range(7) == 0) push_frame(1, 1 + int'($urandom_range(5)));
        end

        // asynchronous reset in the middle of a payload phase
        link_en = 1'b1;
        pct0 = 100; pct1 = 100;
        push_frame(1, 3);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (bus.s0_ready || bus.s1_ready) found = 1'b1;
        end
        check("reach_data_phase", 32'(found), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        pq0.delete();
        pq1.delete();
        repeat (2) @(posedge clk);
        release_reset();

        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (pq0.size() == 0 && $urandom_range(5) == 0) push_frame(0, 1 + int'($urandom_range(5)));
            if (pq1.size() == 0 && $urandom_range(5) == 0) push_frame(1, 1 + int'($urandom_range(5)));
        end
        repeat (40) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
